// File: rtl/i2s_tdm_port_pkg.sv
// Shared audio definitions for the I2S/TDM serial port: frame-format mode,
// port run state and the frame-length helper.
package i2s_tdm_port_pkg;

  typedef enum logic {
    I2S = 1'b0,
    TDM = 1'b1
  } i2s_mode_e;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } port_state_e;

  function automatic int unsigned frame_bits(input int unsigned channels,
                                             input int unsigned slot_width);
    return channels * slot_width;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV clk cycles while run is high
// and flags the clk cycle in which bclk is about to rise or fall.
module i2s_bclk_gen #(
  parameter int unsigned BCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int unsigned CNT_W = $clog2(BCLK_DIV);

  logic [CNT_W-1:0] div_cnt;
  logic             half_done;

  // Strobes are valid in the same cycle the bclk register toggles, so the
  // port logic updates its pins on exactly the same clk edge as bclk.
  assign half_done = run && (div_cnt == CNT_W'(BCLK_DIV - 1));
  assign rise_stb  = half_done && !bclk;
  assign fall_stb  = half_done && bclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (half_done) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2s_tdm_port.sv
// I2S / TDM audio serial port master: one-deep playback holding register,
// MSB-first slot shifter with one-bit data delay, and frame capture on sdin.
module i2s_tdm_port
  import i2s_tdm_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SLOT_WIDTH = 16,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned BCLK_DIV   = 2,
  parameter i2s_mode_e   MODE       = I2S
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [CHANNELS*DATA_WIDTH-1:0] tx_frame,
  input  logic                           tx_valid,
  output logic                           tx_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] rx_frame,
  output logic                           rx_valid,
  output logic                           underrun,
  output logic                           bclk,
  output logic                           lrclk,
  output logic                           sdout,
  input  logic                           sdin
);

  localparam int unsigned FRAME_BITS = frame_bits(CHANNELS, SLOT_WIDTH);
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
  localparam int unsigned PCM_W      = CHANNELS * DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(FRAME_BITS / 2);

  if (DATA_WIDTH < 16 || DATA_WIDTH > 32) begin : g_bad_data_width
    $error("i2s_tdm_port: DATA_WIDTH must be 16..32");
  end
  if (SLOT_WIDTH < DATA_WIDTH) begin : g_bad_slot_width
    $error("i2s_tdm_port: SLOT_WIDTH must be at least DATA_WIDTH");
  end
  if (CHANNELS < 2 || CHANNELS > 8) begin : g_bad_channels
    $error("i2s_tdm_port: CHANNELS must be 2..8");
  end
  if (MODE == I2S && (CHANNELS % 2) != 0) begin : g_bad_i2s_channels
    $error("i2s_tdm_port: I2S mode needs an even CHANNELS");
  end
  if (BCLK_DIV < 2) begin : g_bad_bclk_div
    $error("i2s_tdm_port: BCLK_DIV must be at least 2");
  end

  port_state_e       state_q, state_d;
  logic              run, rise_stb, fall_stb;
  logic              start_evt, wrap_evt, stop_evt, load_evt, accept;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [PCM_W-1:0]  hold_q;
  logic              hold_full_q;
  logic [FRAME_BITS-1:0] shift_q, tx_serial, rx_serial;
  logic [FRAME_BITS-2:0] rx_shift_q;
  logic [PCM_W-1:0]  rx_unpacked;
  logic [1:0]        rx_skip_q;

  assign run = (state_q == ST_RUN);

  i2s_bclk_gen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_bclk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .bclk    (bclk),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb)
  );

  function automatic logic lr_level(input logic [CNT_W-1:0] cnt);
    if (MODE == TDM) return (cnt == LAST_BIT);
    else             return (cnt >= HALF_BIT);
  endfunction

  // en only matters while stopped or at the bclk fall that ends a frame.
  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise a path
    // that skips an assignment infers a latch.
    state_d   = state_q;
    start_evt = 1'b0;
    wrap_evt  = 1'b0;
    stop_evt  = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (en) begin
          state_d   = ST_RUN;
          start_evt = 1'b1;
        end
      end
      ST_RUN: begin
        if (fall_stb && bit_cnt_q == LAST_BIT) begin
          if (en) begin
            wrap_evt = 1'b1;
          end else begin
            stop_evt = 1'b1;
            state_d  = ST_STOP;
          end
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  assign load_evt = start_evt || wrap_evt;
  assign accept   = tx_valid && !hold_full_q;
  assign tx_ready = !hold_full_q;

  // Serial order: slot 0 first, data MSB first, pad bits low in each slot.
  always_comb begin
    tx_serial   = '0;
    rx_unpacked = '0;
    for (int n = 0; n < int'(CHANNELS); n++) begin
      tx_serial[FRAME_BITS-1-n*SLOT_WIDTH -: DATA_WIDTH] = hold_q[n*DATA_WIDTH +: DATA_WIDTH];
      rx_unpacked[n*DATA_WIDTH +: DATA_WIDTH] = rx_serial[FRAME_BITS-1-n*SLOT_WIDTH -: DATA_WIDTH];
    end
  end

  // sdout always takes the shifter MSB at a fall, which yields the one-bit
  // delay: the last bit of a frame leaves during bit period 0 of the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STOP;
      bit_cnt_q <= '0;
      lrclk     <= 1'b0;
      sdout     <= 1'b0;
      shift_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register in this block
      // sees the pre-edge values of the others regardless of statement order.
      state_q <= state_d;
      if (stop_evt) begin
        bit_cnt_q <= '0;
        lrclk     <= 1'b0;
        sdout     <= 1'b0;
        shift_q   <= '0;
      end else if (load_evt) begin
        bit_cnt_q <= '0;
        lrclk     <= lr_level('0);
        sdout     <= shift_q[FRAME_BITS-1];
        shift_q   <= hold_full_q ? tx_serial : '0;
      end else if (fall_stb) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        lrclk     <= lr_level(bit_cnt_q + CNT_W'(1));
        sdout     <= shift_q[FRAME_BITS-1];
        shift_q   <= {shift_q[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  // A load takes the old holding content; an accept in the same cycle keeps
  // the new frame held for the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset as well, so no X can reach the pins
      // or rx_frame even if a load happens before any accept.
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      underrun <= load_evt && !hold_full_q;
      if (accept) begin
        hold_q      <= tx_frame;
        hold_full_q <= 1'b1;
      end else if (load_evt) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  assign rx_serial = {rx_shift_q, sdin};

  // The first two bit-0 rises after a start carry no complete, trusted frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift_q <= '0;
      rx_skip_q  <= '0;
      rx_frame   <= '0;
      rx_valid   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (start_evt) begin
        rx_skip_q <= 2'd2;
      end else if (rise_stb) begin
        rx_shift_q <= {rx_shift_q[FRAME_BITS-3:0], sdin};
        if (bit_cnt_q == '0) begin
          if (rx_skip_q != 2'd0) begin
            rx_skip_q <= rx_skip_q - 2'd1;
          end else begin
            rx_frame <= rx_unpacked;
            rx_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tdm_port.sv
// Directed bench for i2s_tdm_port: an I2S instance with loopback covers reset,
// underrun, stop/restart, holding-register handshake and mid-frame reset; a TDM
// instance covers sync pulse, slot padding and 8-channel loopback.
module tb_i2s_tdm_port;
  import i2s_tdm_port_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // I2S instance, default configuration
  logic        en_a, tx_valid_a, tx_ready_a, rx_valid_a, underrun_a;
  logic        bclk_a, lrclk_a, sdout_a, sdin_a;
  logic [31:0] tx_frame_a, rx_frame_a;
  assign sdin_a = sdout_a;

  // TDM instance, 8 x 24-bit in 32-bit slots
  logic         en_b, tx_valid_b, tx_ready_b, rx_valid_b, underrun_b;
  logic         bclk_b, lrclk_b, sdout_b, sdin_b;
  logic [191:0] tx_frame_b, rx_frame_b;
  assign sdin_b = sdout_b;

  i2s_tdm_port #(
    .DATA_WIDTH(16), .SLOT_WIDTH(16), .CHANNELS(2), .BCLK_DIV(2), .MODE(I2S)
  ) dut_i2s (
    .clk(clk), .rst_n(rst_n), .en(en_a), .tx_frame(tx_frame_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .rx_frame(rx_frame_a), .rx_valid(rx_valid_a),
    .underrun(underrun_a), .bclk(bclk_a), .lrclk(lrclk_a), .sdout(sdout_a), .sdin(sdin_a)
  );

  i2s_tdm_port #(
    .DATA_WIDTH(24), .SLOT_WIDTH(32), .CHANNELS(8), .BCLK_DIV(2), .MODE(TDM)
  ) dut_tdm (
    .clk(clk), .rst_n(rst_n), .en(en_b), .tx_frame(tx_frame_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .rx_frame(rx_frame_b), .rx_valid(rx_valid_b),
    .underrun(underrun_b), .bclk(bclk_b), .lrclk(lrclk_b), .sdout(sdout_b), .sdin(sdin_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected TDM serial bit k of a frame whose channel n carries 0x800000+n.
  function automatic logic tdm_bit(input int k);
    logic [23:0] v;
    v = 24'h800000 + 24'(k / 32);
    return ((k % 32) < 24) ? v[23 - (k % 32)] : 1'b0;
  endfunction

  localparam logic [31:0] FRM_A = 32'h1234_ABCD;
  localparam logic [31:0] FRM_B = 32'hCAFE_5A5A;
  localparam logic [31:0] FRM_C = 32'h0F0F_8001;
  localparam logic [31:0] FRM_D = 32'h7E57_00FF;

  initial begin
    int ur_q[$], rv_q[$], rise_q[$];
    logic [31:0] rv_d[$];
    logic [31:0] fr[4];
    int exp_ur[4], exp_rv[5];
    logic [31:0] exp_rd[5];
    int lr_first, lr_cnt, sd_ones, falls_after, last_fall, high_after_stop;
    int feed_idx, rst_rx, first_rx, bit_err, pad_ones, ur_b, first_rx_b;
    logic prev_bclk, prev_ready;
    logic [3:0] sd_seq;
    logic [191:0] rx_b_data;

    en_a = 1'b0; tx_valid_a = 1'b0; tx_frame_a = '0;
    en_b = 1'b0; tx_valid_b = 1'b0; tx_frame_b = '0;
    for (int n = 0; n < 8; n++) tx_frame_b[n*24 +: 24] = 24'h800000 + 24'(n);

    // ---- reset values
    repeat (3) @(negedge clk);
    check("rst_bclk", bclk_a, 1'b0);
    check("rst_lrclk", lrclk_a, 1'b0);
    check("rst_sdout", sdout_a, 1'b0);
    check("rst_tx_ready", tx_ready_a, 1'b1);
    check("rst_rx_valid", rx_valid_a, 1'b0);
    check("rst_underrun", underrun_a, 1'b0);
    check("rst_rx_frame", rx_frame_a, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- no playback data: underrun every frame, then en drop at bit_cnt 10
    lr_first = 0; lr_cnt = 0; sd_ones = 0; falls_after = 0; last_fall = 0;
    high_after_stop = 0; prev_bclk = bclk_a;
    en_a = 1'b1;
    for (int i = 1; i <= 620; i++) begin
      @(negedge clk);
      if (underrun_a) ur_q.push_back(i);
      if (rx_valid_a) begin
        rv_q.push_back(i);
        check("idle_rx_data", rx_frame_a, 32'h0);
      end
      if (sdout_a) sd_ones++;
      if (i <= 128 && lrclk_a) begin
        lr_cnt++;
        if (lr_first == 0) lr_first = i;
      end
      if (bclk_a && !prev_bclk && rise_q.size() < 2) rise_q.push_back(i);
      if (i > 425 && prev_bclk && !bclk_a) begin
        falls_after++;
        last_fall = i;
      end
      if (i > 520 && (bclk_a || lrclk_a || sdout_a)) high_after_stop++;
      prev_bclk = bclk_a;
      if (i == 425) en_a = 1'b0;
    end
    exp_ur = '{1, 129, 257, 385};
    check("underrun_count", ur_q.size(), 4);
    for (int k = 0; k < ur_q.size() && k < 4; k++) check("underrun_cycle", ur_q[k], exp_ur[k]);
    check("idle_rx_count", rv_q.size(), 2);
    if (rv_q.size() > 0) check("first_rx_cycle", rv_q[0], 259);
    check("bclk_rise_count", rise_q.size(), 2);
    if (rise_q.size() == 2) begin
      check("bclk_first_rise", rise_q[0], 3);
      check("bclk_period", rise_q[1] - rise_q[0], 4);
    end
    check("i2s_lrclk_first", lr_first, 65);
    check("i2s_lrclk_high", lr_cnt, 64);
    check("underrun_sdout_zero", sd_ones, 0);
    check("stop_fall_count", falls_after, 22);
    check("stop_last_fall", last_fall, 513);
    check("stopped_pins_low", high_after_stop, 0);

    // ---- loopback with handshake, same-cycle accept/load at a boundary
    @(negedge clk);
    check("ready_stopped", tx_ready_a, 1'b1);
    tx_frame_a = FRM_A; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    check("ready_after_accept", tx_ready_a, 1'b0);
    en_a = 1'b1;
    fr = '{FRM_A, FRM_A, FRM_B, FRM_C};
    feed_idx = 1; prev_ready = tx_ready_a; sd_seq = '0;
    ur_q.delete(); rv_q.delete();
    for (int i = 1; i <= 851; i++) begin
      @(negedge clk);
      if (underrun_a) ur_q.push_back(i);
      if (rx_valid_a) begin
        rv_q.push_back(i);
        rv_d.push_back(rx_frame_a);
      end
      if (i == 1 || i == 5 || i == 9 || i == 13) sd_seq = {sd_seq[2:0], sdout_a};
      if (i == 513) check("collide_ready_low", tx_ready_a, 1'b0);
      if (i == 600) check("held_ready_low", tx_ready_a, 1'b0);
      if (i == 641) check("held_loaded_ready", tx_ready_a, 1'b1);
      if (tx_valid_a && prev_ready) feed_idx++;
      tx_valid_a = (feed_idx < 4);
      if (feed_idx < 4) tx_frame_a = fr[feed_idx];
      if (i == 512) begin
        tx_valid_a = 1'b1;
        tx_frame_a = FRM_D;
      end
      prev_ready = tx_ready_a;
    end
    check("sdout_bit_delay", sd_seq, 4'b0101);
    exp_rv = '{259, 387, 515, 643, 771};
    exp_rd = '{FRM_A, FRM_B, FRM_C, 32'h0, FRM_D};
    check("loop_rx_count", rv_q.size(), 5);
    for (int k = 0; k < rv_q.size() && k < 5; k++) begin
      check("loop_rx_cycle", rv_q[k], exp_rv[k]);
      check("loop_rx_data", rv_d[k], exp_rd[k]);
    end
    check("loop_underrun_count", ur_q.size(), 2);
    if (ur_q.size() == 2) begin
      check("collide_underrun", ur_q[0], 513);
      check("late_underrun", ur_q[1], 769);
    end

    // ---- asynchronous reset at bit_cnt 20 while bclk and lrclk are high
    check("pre_reset_bclk", bclk_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_bclk", bclk_a, 1'b0);
    check("async_lrclk", lrclk_a, 1'b0);
    check("async_sdout", sdout_a, 1'b0);
    check("async_tx_ready", tx_ready_a, 1'b1);
    check("async_rx_frame", rx_frame_a, 32'h0);
    rst_rx = 0;
    repeat (5) begin
      @(negedge clk);
      if (rx_valid_a) rst_rx++;
    end
    check("reset_no_rx", rst_rx, 0);
    rst_n = 1'b1;
    first_rx = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (rx_valid_a && first_rx == 0) first_rx = i;
    end
    check("restart_first_rx", first_rx, 259);
    en_a = 1'b0;

    // ---- TDM: 8 x 24-bit in 32-bit slots, continuous feed, loopback
    @(negedge clk);
    tx_valid_b = 1'b1;
    @(negedge clk);
    en_b = 1'b1;
    lr_first = 0; lr_cnt = 0; bit_err = 0; pad_ones = 0; ur_b = 0; first_rx_b = 0;
    rx_b_data = '0;
    for (int i = 1; i <= 2100; i++) begin
      @(negedge clk);
      if (underrun_b) ur_b++;
      if (rx_valid_b && first_rx_b == 0) begin
        first_rx_b = i;
        rx_b_data  = rx_frame_b;
      end
      if (i <= 2048) begin
        if (lrclk_b) begin
          lr_cnt++;
          if (lr_first == 0) lr_first = i;
        end
        if ((i - 1) % 4 == 1) begin
          int p, m;
          logic e;
          m = (i - 1) / 1024;
          p = ((i - 1) % 1024) / 4;
          if (p >= 1) e = tdm_bit(p - 1);
          else        e = (m == 0) ? 1'b0 : tdm_bit(255);
          if (sdout_b !== e) bit_err++;
          if (p >= 1 && ((p - 1) % 32) >= 24 && sdout_b) pad_ones++;
        end
      end
    end
    check("tdm_lrclk_first", lr_first, 1021);
    check("tdm_lrclk_high", lr_cnt, 8);
    check("tdm_sdout_bits", bit_err, 0);
    check("tdm_pad_zero", pad_ones, 0);
    check("tdm_no_underrun", ur_b, 0);
    check("tdm_first_rx", first_rx_b, 2051);
    check("tdm_rx_data", rx_b_data, tx_frame_b);
    en_b = 1'b0;
    tx_valid_b = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
